// File: rtl/reg_check_harness.sv
// reg_check_harness: runs the processor for a set number of cycles, traces
// every register-file write into a FIFO, then sweeps the regfile through
// read port A and compares each register against an expected-value ROM.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start after reset
// S_RUN   | processor running, regfile writes captured into the trace
// S_CHECK | regfile swept via port A, one-stage compare pipeline
// S_DONE  | results held until start or reset
module reg_check_harness #(
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 32,
    parameter int ADDR_W      = 5,
    parameter int CYC_W       = 16,
    parameter int TRACE_DEPTH = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CYC_W-1:0]  num_cycles,
    input  logic              rwe,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] rdata,
    output logic              test_mode,
    output logic [ADDR_W-1:0] test_addr,
    input  logic [DATA_W-1:0] reg_data,
    input  logic [DATA_W-1:0] exp_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   error_count,
    output logic              first_fail_valid,
    output logic [ADDR_W-1:0] first_fail_reg,
    input  logic              trace_pop,
    output logic              trace_valid,
    output logic [CYC_W-1:0]  trace_cycle,
    output logic [ADDR_W-1:0] trace_rd,
    output logic [DATA_W-1:0] trace_data,
    output logic              trace_overflow
);

    localparam int PTR_W = $clog2(TRACE_DEPTH);
    // r_chk counts 0..NUM_REGS; the final value is the compare drain cycle.
    localparam logic [ADDR_W:0] LAST_CHK = (ADDR_W+1)'(NUM_REGS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CYC_W-1:0]  r_cnt;
    logic [CYC_W-1:0]  r_n;
    logic [ADDR_W:0]   r_chk;
    logic              r_pipe_vld;
    logic [DATA_W-1:0] r_pipe_reg;
    logic [DATA_W-1:0] r_pipe_exp;
    logic [ADDR_W-1:0] r_pipe_addr;
    logic [ADDR_W:0]   r_err;
    logic              r_ffv;
    logic [ADDR_W-1:0] r_ffr;
    logic [PTR_W:0]    r_wr;
    logic [PTR_W:0]    r_rd;
    logic              r_ovf;
    logic [CYC_W-1:0]  r_mem_cyc  [TRACE_DEPTH];
    logic [ADDR_W-1:0] r_mem_rd   [TRACE_DEPTH];
    logic [DATA_W-1:0] r_mem_data [TRACE_DEPTH];

    logic w_start_ok;
    logic w_run_last;
    logic w_chk_last;
    logic w_capture;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    // N=0 still spends one RUN cycle, but with capture suppressed.
    assign w_run_last = (r_n == '0) || (r_cnt == (r_n - CYC_W'(1)));
    assign w_chk_last = (r_chk == LAST_CHK);
    assign w_capture  = (r_state == S_RUN) && (r_n != '0) && rwe && (rd != '0);

    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[PTR_W] != r_rd[PTR_W]) &&
                     (r_wr[PTR_W-1:0] == r_rd[PTR_W-1:0]);
    assign w_pop   = trace_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = w_capture && (!w_full || w_pop);
    assign w_drop  = w_capture && w_full && !w_pop;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)      w_next = S_RUN;
            S_RUN:   if (w_run_last) w_next = S_CHECK;
            S_CHECK: if (w_chk_last) w_next = S_DONE;
            S_DONE:  if (start)      w_next = S_RUN;
            default:                 w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy      = (r_state == S_RUN) || (r_state == S_CHECK);
        done      = (r_state == S_DONE);
        test_mode = (r_state == S_CHECK);
        test_addr = ((r_state == S_CHECK) && !w_chk_last) ? r_chk[ADDR_W-1:0] : '0;
        pass      = (r_state == S_DONE) && (r_err == '0);
    end

    // Run-length latch and run-cycle counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
            r_n   <= '0;
        end else if (w_start_ok) begin
            r_cnt <= '0;
            r_n   <= num_cycles;
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + CYC_W'(1);
        end
    end

    // Register sweep, compare pipeline and error bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_chk       <= '0;
            r_pipe_vld  <= 1'b0;
            r_pipe_reg  <= '0;
            r_pipe_exp  <= '0;
            r_pipe_addr <= '0;
            r_err       <= '0;
            r_ffv       <= 1'b0;
            r_ffr       <= '0;
        end else if (w_start_ok) begin
            r_chk      <= '0;
            r_pipe_vld <= 1'b0;
            r_err      <= '0;
            r_ffv      <= 1'b0;
            r_ffr      <= '0;
        end else if (r_state == S_CHECK) begin
            if (!w_chk_last) begin
                r_chk       <= r_chk + (ADDR_W+1)'(1);
                r_pipe_vld  <= 1'b1;
                r_pipe_reg  <= reg_data;
                r_pipe_exp  <= exp_data;
                r_pipe_addr <= r_chk[ADDR_W-1:0];
            end else begin
                r_pipe_vld  <= 1'b0;
            end
            if (r_pipe_vld && (r_pipe_reg != r_pipe_exp)) begin
                if (r_err != '1) r_err <= r_err + (ADDR_W+1)'(1);
                if (!r_ffv) begin
                    r_ffv <= 1'b1;
                    r_ffr <= r_pipe_addr;
                end
            end
        end
    end

    assign error_count      = r_err;
    assign first_fail_valid = r_ffv;
    assign first_fail_reg   = r_ffr;

    // Trace FIFO pointers and sticky overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_ovf <= 1'b0;
        end else if (w_start_ok) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_push) r_wr  <= r_wr + (PTR_W+1)'(1);
            if (w_pop)  r_rd  <= r_rd + (PTR_W+1)'(1);
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    // Trace FIFO storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_cyc[r_wr[PTR_W-1:0]]  <= r_cnt;
            r_mem_rd[r_wr[PTR_W-1:0]]   <= rd;
            r_mem_data[r_wr[PTR_W-1:0]] <= rdata;
        end
    end

    assign trace_valid    = !w_empty;
    assign trace_cycle    = w_empty ? '0 : r_mem_cyc[r_rd[PTR_W-1:0]];
    assign trace_rd       = w_empty ? '0 : r_mem_rd[r_rd[PTR_W-1:0]];
    assign trace_data     = w_empty ? '0 : r_mem_data[r_rd[PTR_W-1:0]];
    assign trace_overflow = r_ovf;

endmodule

// File: doc/reg_check_harness.md
# reg_check_harness

Synthesizable run-and-check harness for the single-cycle processor test bench. It runs the CPU for a programmable number of cycles and captures every register-file write (rd ≠ 0) into a timestamped trace FIFO. It then takes over the regfile read port A, sweeps all registers and compares each against an expected-value memory, reporting pass/fail, an error count and the first failing register. It sits between the processor, the regfile's read-A mux and an expected-value ROM, and replaces the fixed 32×32 behavioural checking with a parametrised, cycle-exact block.

## Interface
Parameters:
- DATA_W, 32, register data width
- NUM_REGS, 32, registers swept (≤ 2^ADDR_W)
- ADDR_W, 5, register index width
- CYC_W, 16, run-cycle counter width
- TRACE_DEPTH, 16, trace FIFO entries (power of two)

Ports:
- clock  in  1  sole clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  begin run; accepted only in IDLE or DONE
- num_cycles  in  CYC_W  run length, sampled when start is accepted
- rwe  in  1  processor regfile write enable
- rd  in  ADDR_W  processor write register
- rdata  in  DATA_W  processor write data
- test_mode  out  1  high selects test_addr onto regfile read port A
- test_addr  out  ADDR_W  register being read during CHECK
- reg_data  in  DATA_W  regfile port A data for test_addr
- exp_data  in  DATA_W  expected value for test_addr (external ROM indexed by test_addr)
- busy  out  1  high in RUN and CHECK
- done  out  1  high in DONE
- pass  out  1  valid while done; 1 iff error_count == 0
- error_count  out  ADDR_W+1  mismatches, saturating
- first_fail_valid  out  1  at least one mismatch seen
- first_fail_reg  out  ADDR_W  index of first mismatch
- trace_pop  in  1  consume head of trace FIFO
- trace_valid  out  1  FIFO non-empty
- trace_cycle  out  CYC_W  cycle stamp of head entry
- trace_rd  out  ADDR_W  register of head entry
- trace_data  out  DATA_W  data of head entry
- trace_overflow  out  1  sticky; a write was dropped because the FIFO was full

## Operation
- States: IDLE → RUN → CHECK → DONE; DONE → RUN on start.
- Reset: state IDLE. All outputs 0: test_mode, test_addr, busy, done, pass, error_count, first_fail_*, trace_valid, trace_overflow. FIFO empty; its head fields read 0.
- Start acceptance (IDLE/DONE, start=1):
  - latch num_cycles; cycle counter cnt=0
  - empty the FIFO, clear overflow, error_count and first_fail_*
  - go to RUN
- start is ignored in RUN and CHECK.
- RUN:
  - each cycle, if rwe && rd≠0, push {cnt, rd, rdata}
  - cnt increments each cycle; after cnt reaches N−1, go to CHECK
  - N=0: the first RUN cycle performs no capture and goes directly to CHECK
- CHECK:
  - test_mode=1; test_addr steps 0..NUM_REGS−1, one per cycle
  - one-stage compare pipeline: reg_data/exp_data for address k are registered on the edge that advances to k+1 and compared the following cycle
  - a mismatch increments error_count (saturating at all-ones); the first mismatch records first_fail_reg=k
  - after the last compare, go to DONE; test_mode drops on entry to DONE
- DONE: done=1, pass=(error_count==0). Results hold until reset or start.
- Trace FIFO:
  - push when not full; when full, drop the new entry and set trace_overflow
  - pop on trace_pop && trace_valid; pop on empty is a no-op
  - push and pop in the same cycle when full: both occur, count unchanged, no overflow
  - popping is allowed in any state

## Timing
- Start accepted at edge t: busy=1 from t; the cycle after t is run cycle 0, with cnt=0.
- RUN lasts max(N,1) cycles.
- CHECK lasts NUM_REGS+1 cycles: NUM_REGS address cycles plus one compare drain cycle.
- done asserts exactly max(N,1)+NUM_REGS+1 cycles after the start edge.
- The trace entry for a write sampled in run cycle c carries trace_cycle=c and is visible (trace_valid) the next cycle.
- Reset mid-run or mid-check: the next cycle is IDLE with all outputs at reset values, and test_mode releases immediately.

## Test plan
- Reset in RUN with N=100 at cycle 40 → next cycle busy=0, test_mode=0, trace_valid=0; a subsequent start runs normally.
- N=5; rwe=1 with rd=3, rdata=7 in cycle 1 and rd=0 in cycle 2; regfile matches ROM → one trace entry {1,3,7}; done at start+1+5+33 with NUM_REGS=32; pass=1, error_count=0.
- ROM differs at regs 4 and 9 → error_count=2, first_fail_reg=4, pass=0, first_fail_valid=1.
- TRACE_DEPTH=16, N=20, rwe=1 with rd=1 every cycle, no pops → 16 entries with stamps 0..15, trace_overflow=1; pop four → stamps 0,1,2,3 in order.
- N=0 → RUN lasts 1 cycle with no capture; done after 1+NUM_REGS+1 cycles.
- start pulsed during CHECK → ignored; a start in DONE clears the previous results and the FIFO and reruns.
